// File: rtl/clk_reset_seq.sv
// clk_reset_seq: sequenced SoC reset generator driven by PLL lock and a board button.
// Peripherals leave reset after lock has been stable for LOCK_CYCLES, the CPU
// follows CPU_DELAY cycles later. Lock loss or a debounced button press re-arms
// the whole sequence. Lock losses seen after peripheral release are counted.
module clk_reset_seq #(
    parameter int unsigned LOCK_CYCLES = 1024,
    parameter int unsigned CPU_DELAY   = 64,
    parameter int unsigned BTN_CYCLES  = 65536,
    parameter int unsigned CNT_W       = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       btn,
    output logic       periph_rst,
    output logic       cpu_rst,
    output logic       ready,
    output logic       locked_s,
    output logic [7:0] loss_count
);

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CPU_LAST  = CNT_W'(CPU_DELAY - 1);
    localparam logic [CNT_W-1:0] BTN_LAST  = CNT_W'(BTN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HOLD       = 2'd0,
        S_STABLE     = 2'd1,
        S_REL_PERIPH = 2'd2,
        S_RUN        = 2'd3
    } state_t;

    logic             r_lock_meta;
    logic             r_lock_sync;
    logic             r_btn_meta;
    logic             r_btn_sync;
    logic [CNT_W-1:0] r_btn_cnt;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;
    logic             r_periph_rst;
    logic             r_cpu_rst;
    logic             r_ready;
    logic [7:0]       r_loss_count;

    logic             w_btn_req;
    logic             w_abort;
    logic             w_count_loss;

    // Button request is live only while the synchronized button is still high,
    // so it drops in the same cycle the button is seen released.
    assign w_btn_req    = r_btn_sync && (r_btn_cnt == BTN_LAST);
    assign w_abort      = (r_state != S_HOLD) && (!r_lock_sync || w_btn_req);
    assign w_count_loss = w_abort && !r_lock_sync &&
                          ((r_state == S_REL_PERIPH) || (r_state == S_RUN));

    // Two-flop synchronizers for the asynchronous lock flag and button.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
            r_btn_meta  <= 1'b0;
            r_btn_sync  <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_sync <= r_lock_meta;
            r_btn_meta  <= btn;
            r_btn_sync  <= r_btn_meta;
        end
    end

    // Debounce counter: runs while the button is held, saturates at the press threshold.
    always_ff @(posedge clk) begin
        if (rst || !r_btn_sync) begin
            r_btn_cnt <= '0;
        end else if (r_btn_cnt != BTN_LAST) begin
            r_btn_cnt <= r_btn_cnt + CNT_W'(1);
        end
    end

    // Reset sequencing FSM; abort wins over a count completing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_HOLD;
            r_cnt        <= '0;
            r_periph_rst <= 1'b1;
            r_cpu_rst    <= 1'b1;
            r_ready      <= 1'b0;
        end else if (w_abort) begin
            r_state      <= S_HOLD;
            r_cnt        <= '0;
            r_periph_rst <= 1'b1;
            r_cpu_rst    <= 1'b1;
            r_ready      <= 1'b0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    r_cnt        <= '0;
                    r_periph_rst <= 1'b1;
                    r_cpu_rst    <= 1'b1;
                    r_ready      <= 1'b0;
                    if (r_lock_sync && !w_btn_req) begin
                        r_state <= S_STABLE;
                    end
                end
                S_STABLE: begin
                    if (r_cnt == LOCK_LAST) begin
                        r_state      <= S_REL_PERIPH;
                        r_cnt        <= '0;
                        r_periph_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_REL_PERIPH: begin
                    if (r_cnt == CPU_LAST) begin
                        r_state   <= S_RUN;
                        r_cnt     <= '0;
                        r_cpu_rst <= 1'b0;
                        r_ready   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    r_periph_rst <= 1'b0;
                    r_cpu_rst    <= 1'b0;
                    r_ready      <= 1'b1;
                end
                default: begin
                    r_state <= S_HOLD;
                end
            endcase
        end
    end

    // Saturating count of lock losses that hit a released system.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_loss_count <= 8'd0;
        end else if (w_count_loss && (r_loss_count != 8'hFF)) begin
            r_loss_count <= r_loss_count + 8'd1;
        end
    end

    assign periph_rst = r_periph_rst;
    assign cpu_rst    = r_cpu_rst;
    assign ready      = r_ready;
    assign locked_s   = r_lock_sync;
    assign loss_count = r_loss_count;

endmodule

// File: tb/tb_clk_reset_seq.sv
// Directed bench for clk_reset_seq with small sequencing constants.
module tb_clk_reset_seq;

    localparam int unsigned L = 16;
    localparam int unsigned D = 8;
    localparam int unsigned B = 8;

    logic       clk;
    logic       rst;
    logic       pll_locked;
    logic       btn;
    logic       periph_rst;
    logic       cpu_rst;
    logic       ready;
    logic       locked_s;
    logic [7:0] loss_count;

    int n_cmp = 0;
    int n_bad = 0;

    clk_reset_seq #(
        .LOCK_CYCLES(L),
        .CPU_DELAY  (D),
        .BTN_CYCLES (B),
        .CNT_W      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .btn       (btn),
        .periph_rst(periph_rst),
        .cpu_rst   (cpu_rst),
        .ready     (ready),
        .locked_s  (locked_s),
        .loss_count(loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ordering invariants, sampled on the falling edge throughout the run.
    always @(negedge clk) begin
        n_cmp++;
        if (cpu_rst === 1'b0 && periph_rst !== 1'b0) begin
            n_bad++;
            $display("FAIL inv_cpu_periph t=%0t cpu_rst=%b periph_rst=%b (need periph_rst=0)", $time, cpu_rst, periph_rst);
        end
        n_cmp++;
        if (ready === 1'b1 && cpu_rst !== 1'b0) begin
            n_bad++;
            $display("FAIL inv_ready_cpu t=%0t ready=%b cpu_rst=%b (need cpu_rst=0)", $time, ready, cpu_rst);
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int budget);
        int k = 0;
        while (ready !== 1'b1 && k < budget) begin
            wait_edges(1);
            k++;
        end
        n_cmp++;
        if (ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_timeout ready=%b after %0d edges (need 1)", ready, k);
        end
    endtask

    // Caller has just driven the last enabling input; the next edge is s.
    // fresh=1: lock synchronizer starts empty; fresh=0: lock already synchronized.
    task automatic seq_release(input bit fresh);
        logic exp_ls;
        exp_ls = fresh ? 1'b0 : 1'b1;
        wait_edges(1);
        n_cmp++;
        if (locked_s !== exp_ls) begin
            n_bad++; $display("FAIL rel_sync_s locked_s=%b exp=%b", locked_s, exp_ls);
        end
        wait_edges(1);
        n_cmp++;
        if (locked_s !== 1'b1) begin
            n_bad++; $display("FAIL rel_sync_s1 locked_s=%b exp=1", locked_s);
        end
        wait_edges(L);
        n_cmp++;
        if (periph_rst !== 1'b1) begin
            n_bad++; $display("FAIL rel_periph_early periph_rst=%b exp=1", periph_rst);
        end
        wait_edges(1);
        n_cmp++;
        if ({periph_rst, cpu_rst, ready} !== 3'b010) begin
            n_bad++; $display("FAIL rel_periph {p,c,r}=%b exp=010", {periph_rst, cpu_rst, ready});
        end
        wait_edges(D - 1);
        n_cmp++;
        if ({cpu_rst, ready} !== 2'b10) begin
            n_bad++; $display("FAIL rel_cpu_early {c,r}=%b exp=10", {cpu_rst, ready});
        end
        wait_edges(1);
        n_cmp++;
        if ({periph_rst, cpu_rst, ready} !== 3'b001) begin
            n_bad++; $display("FAIL rel_cpu {p,c,r}=%b exp=001", {periph_rst, cpu_rst, ready});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pll_locked = 1'b0; btn = 1'b0;
        wait_edges(3);
        n_cmp++;
        if ({periph_rst, cpu_rst, ready, locked_s} !== 4'b1100 || loss_count !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_state {p,c,r,ls}=%b loss=%0d exp=1100 loss=0", {periph_rst, cpu_rst, ready, locked_s}, loss_count);
        end
    endtask

    task automatic test_powerup();
        rst = 1'b0; pll_locked = 1'b1;
        seq_release(1'b1);
        n_cmp++;
        if (loss_count !== 8'd0) begin
            n_bad++; $display("FAIL powerup_loss loss=%0d exp=0", loss_count);
        end
    endtask

    task automatic test_button();
        int lens [4] = '{7, 3, 1, 5};
        foreach (lens[i]) begin
            btn = 1'b1;
            wait_edges(lens[i]);
            btn = 1'b0;
            wait_edges(4);
            n_cmp++;
            if ({periph_rst, cpu_rst, ready} !== 3'b001) begin
                n_bad++; $display("FAIL btn_short len=%0d {p,c,r}=%b exp=001", lens[i], {periph_rst, cpu_rst, ready});
            end
        end
        btn = 1'b1;
        wait_edges(B + 1);
        n_cmp++;
        if ({periph_rst, cpu_rst, ready} !== 3'b001) begin
            n_bad++; $display("FAIL btn_early {p,c,r}=%b exp=001", {periph_rst, cpu_rst, ready});
        end
        wait_edges(1);
        n_cmp++;
        if ({periph_rst, cpu_rst, ready} !== 3'b110 || loss_count !== 8'd0) begin
            n_bad++; $display("FAIL btn_abort {p,c,r}=%b loss=%0d exp=110 loss=0", {periph_rst, cpu_rst, ready}, loss_count);
        end
        wait_edges(10);
        n_cmp++;
        if ({periph_rst, cpu_rst} !== 2'b11) begin
            n_bad++; $display("FAIL btn_held {p,c}=%b exp=11", {periph_rst, cpu_rst});
        end
        btn = 1'b0;
        seq_release(1'b0);
        n_cmp++;
        if (loss_count !== 8'd0) begin
            n_bad++; $display("FAIL btn_loss loss=%0d exp=0", loss_count);
        end
    endtask

    task automatic test_simultaneous();
        rst = 1'b1; pll_locked = 1'b0;
        wait_edges(2);
        rst = 1'b0; pll_locked = 1'b1;
        wait_edges(L + 3);
        n_cmp++;
        if ({periph_rst, cpu_rst} !== 2'b01) begin
            n_bad++; $display("FAIL sim_rel {p,c}=%b exp=01", {periph_rst, cpu_rst});
        end
        wait_edges(D - 3);
        pll_locked = 1'b0;
        wait_edges(2);
        n_cmp++;
        if ({periph_rst, cpu_rst} !== 2'b01) begin
            n_bad++; $display("FAIL sim_pre {p,c}=%b exp=01", {periph_rst, cpu_rst});
        end
        wait_edges(1);
        n_cmp++;
        if ({periph_rst, cpu_rst, ready} !== 3'b110 || loss_count !== 8'd1) begin
            n_bad++; $display("FAIL sim_abort {p,c,r}=%b loss=%0d exp=110 loss=1", {periph_rst, cpu_rst, ready}, loss_count);
        end
        for (int i = 0; i < 5; i++) begin
            wait_edges(1);
            n_cmp++;
            if (cpu_rst !== 1'b1) begin
                n_bad++; $display("FAIL sim_cpu_hold cpu_rst=%b exp=1", cpu_rst);
            end
        end
    endtask

    task automatic test_rst_mid();
        pll_locked = 1'b1;
        wait_edges(L + 5);
        n_cmp++;
        if ({periph_rst, cpu_rst} !== 2'b01 || loss_count !== 8'd1) begin
            n_bad++; $display("FAIL mid_pre {p,c}=%b loss=%0d exp=01 loss=1", {periph_rst, cpu_rst}, loss_count);
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wait_edges(1);
            n_cmp++;
            if ({periph_rst, cpu_rst, ready, locked_s} !== 4'b1100 || loss_count !== 8'd0) begin
                n_bad++;
                $display("FAIL mid_reset {p,c,r,ls}=%b loss=%0d exp=1100 loss=0", {periph_rst, cpu_rst, ready, locked_s}, loss_count);
            end
        end
        rst = 1'b0;
        seq_release(1'b1);
    endtask

    task automatic test_flicker();
        rst = 1'b1; pll_locked = 1'b0;
        wait_edges(2);
        rst = 1'b0; pll_locked = 1'b1;
        wait_edges(10);
        pll_locked = 1'b0;
        wait_edges(4);
        n_cmp++;
        if ({periph_rst, ready} !== 2'b10) begin
            n_bad++; $display("FAIL flick_hold {p,r}=%b exp=10", {periph_rst, ready});
        end
        pll_locked = 1'b1;
        seq_release(1'b1);
        n_cmp++;
        if (loss_count !== 8'd0) begin
            n_bad++; $display("FAIL flick_loss loss=%0d exp=0", loss_count);
        end
    endtask

    task automatic test_lock_loss_run();
        logic [7:0] exp_loss;
        for (int i = 0; i < 300; i++) begin
            exp_loss = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
            pll_locked = 1'b0;
            wait_edges(2);
            n_cmp++;
            if (ready !== 1'b1) begin
                n_bad++; $display("FAIL loss_early it=%0d ready=%b exp=1", i, ready);
            end
            wait_edges(1);
            n_cmp++;
            if ({periph_rst, cpu_rst, ready} !== 3'b110 || loss_count !== exp_loss) begin
                n_bad++;
                $display("FAIL loss_abort it=%0d {p,c,r}=%b loss=%0d exp=110 loss=%0d", i, {periph_rst, cpu_rst, ready}, loss_count, exp_loss);
            end
            pll_locked = 1'b1;
            wait_ready(L + D + 20);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            if (pll_locked) begin
                if ($urandom_range(0, 59) == 0) pll_locked = 1'b0;
            end else if ($urandom_range(0, 4) == 0) begin
                pll_locked = 1'b1;
            end
            if (btn) begin
                if ($urandom_range(0, 3) == 0) btn = 1'b0;
            end else if ($urandom_range(0, 199) == 0) begin
                btn = 1'b1;
            end
            wait_edges(1);
        end
        pll_locked = 1'b1; btn = 1'b0;
        wait_edges(4);
        wait_ready(L + D + 20);
    endtask

    initial begin
        rst = 1'b1; pll_locked = 1'b0; btn = 1'b0;
        test_reset();
        test_powerup();
        test_button();
        test_simultaneous();
        test_rst_mid();
        test_flicker();
        test_lock_loss_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
